pipe_stage_elastic: RTL and testbench

- Parametrised elastic pipeline register that generalises the fixed inter-stage latches of the five-stage core (fetch/decode, decode/execute and the later stages).
- Carries an arbitrary-width payload with a valid/ready handshake, so any stage can stall upstream by holding ready low.
- Supports flush for killing wrong-path instructions and an optional skid buffer that removes the combinational ready path.
- Counts downstream stall cycles for performance bring-up.

---
 rtl/pipe_stage_elastic.sv | 69 ++++++
 tb/tb_pipe_stage_elastic.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline register with flush, optional skid buffer and saturating stall counter
module pipe_stage_elastic #(
  parameter int DATA_W = 64,
  parameter int SKID = 1,
  parameter int CNT_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'b00, BUSY = 2'b10, FULL = 2'b11} state_t;
  logic in_fire, out_fire;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  if (SKID != 0) begin : g_skid
    state_t state, state_n;
    logic [DATA_W-1:0] main_q, skid_q;
    always_comb begin
      state_n = flush ? EMPTY :
                state == EMPTY ? (in_fire ? BUSY : EMPTY) :
                state == BUSY ? ((in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : BUSY) :
                (out_fire ? BUSY : FULL);
    end
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        state <= EMPTY;
        main_q <= '0;
        skid_q <= '0;
      end else begin
        state <= state_n;
        if (~flush & in_fire & (state == EMPTY | out_fire)) main_q <= in_data;
        else if (~flush & (state == FULL) & out_fire) main_q <= skid_q;
        if (~flush & in_fire & (state == BUSY) & ~out_fire) skid_q <= in_data;
      end
    end
    assign in_ready = ~state[0];
    assign out_valid = state[1];
    assign out_data = main_q;
    assign occupancy = {state[1] & state[0], state[1] ^ state[0]};
  end else begin : g_reg
    logic v;
    logic [DATA_W-1:0] q;
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        v <= 1'b0;
        q <= '0;
      end else begin
        v <= ~flush & (in_fire | (v & ~out_ready));
        if (in_fire & ~flush) q <= in_data;
      end
    end
    assign in_ready = ~v | out_ready;
    assign out_valid = v;
    assign out_data = q;
    assign occupancy = {1'b0, v};
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench driving a SKID=0 and a SKID=1 instance against a queue-based reference model
module tb_pipe_stage_elastic;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] iv, ord, fl, rs, rdy, ov;
  logic [1:0][15:0] id, od;
  logic [1:0][1:0] occ;
  logic [1:0][3:0] sc;
  pipe_stage_elastic #(.DATA_W(16), .SKID(0), .CNT_W(4)) u0 (
    .sys_clk(clk), .sys_rst(rs[0]), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ord[0]), .out_data(od[0]), .flush(fl[0]),
    .occupancy(occ[0]), .stall_cnt(sc[0]));
  pipe_stage_elastic #(.DATA_W(16), .SKID(1), .CNT_W(4)) u1 (
    .sys_clk(clk), .sys_rst(rs[1]), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ord[1]), .out_data(od[1]), .flush(fl[1]),
    .occupancy(occ[1]), .stall_cnt(sc[1]));
  int tests = 0, fails = 0, xfers = 0;
  logic [15:0] sb [2][$];
  int cnt [2];
  bit exp_rdy [2], exp_v [2], zero [2], armed [2], acc [2];
  function automatic void chk(string nm, int k, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, a, e, $time);
    end
  endfunction
  // capacity-limited FIFO view of the stage: ready when not full (SKID=1) or when the sole slot drains (SKID=0)
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int n;
      n = sb[k].size();
      exp_rdy[k] = (k == 1) ? (n < 2) : (n == 0 || ord[k]);
      exp_v[k] = n > 0;
      if (armed[k]) begin
        chk("out_valid", k, 32'(ov[k]), 32'(n > 0));
        chk("occupancy", k, 32'(occ[k]), 32'(n));
        chk("in_ready", k, 32'(rdy[k]), 32'(exp_rdy[k]));
        chk("stall_cnt", k, 32'(sc[k]), 32'(cnt[k]));
        if (n > 0) chk("out_data", k, 32'(od[k]), 32'(sb[k][0]));
        else if (zero[k]) chk("reset_data", k, 32'(od[k]), 32'd0);
      end
      if (n > 0 && ord[k]) begin
        void'(sb[k].pop_front());
        xfers++;
      end
    end
  end
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      acc[k] = iv[k] & exp_rdy[k];
      if (rs[k]) begin
        sb[k].delete();
        cnt[k] = 0;
        zero[k] = 1'b1;
        armed[k] = 1'b1;
      end else begin
        if (exp_v[k] && !ord[k] && cnt[k] < 15) cnt[k]++;
        if (fl[k]) sb[k].delete();
        else if (acc[k]) begin
          sb[k].push_back(id[k]);
          zero[k] = 1'b0;
        end
      end
    end
  end
  task automatic set(int k, bit v, logic [15:0] d, bit o, bit f, bit r);
    iv[k] = v; id[k] = d; ord[k] = o; fl[k] = f; rs[k] = r;
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      set(k, 0, 16'h0, 1, 0, 1);
      cnt[k] = 0; exp_rdy[k] = 1; exp_v[k] = 0; zero[k] = 1; armed[k] = 0; acc[k] = 0;
    end
    tick(2);
    set(0, 0, 16'h0, 1, 0, 0);
    set(1, 0, 16'h0, 1, 0, 0);
    tick();
    set(1, 1, 16'h10, 1, 0, 0); tick();
    set(1, 1, 16'h11, 1, 0, 0); tick();
    set(1, 1, 16'h12, 1, 0, 0); tick();
    set(1, 0, 16'h0, 1, 0, 0); tick(2);
    set(1, 1, 16'hA1, 0, 0, 0); tick();
    set(1, 1, 16'hA2, 0, 0, 0); tick();
    set(1, 1, 16'hA3, 0, 0, 0); tick();
    set(1, 1, 16'hA3, 1, 0, 0); tick(2);
    set(1, 0, 16'h0, 1, 0, 0); tick(2);
    set(1, 1, 16'hB1, 0, 0, 0); tick();
    set(1, 1, 16'hB2, 0, 0, 0); tick();
    set(1, 1, 16'hB3, 0, 1, 0); tick();
    set(1, 0, 16'h0, 1, 0, 0); tick(2);
    set(1, 1, 16'hC1, 0, 0, 0); tick();
    set(1, 0, 16'h0, 1, 1, 0); tick();
    set(1, 0, 16'h0, 1, 0, 0); tick(2);
    set(0, 1, 16'hD1, 0, 0, 0); tick();
    set(0, 1, 16'hD2, 0, 0, 0); tick(2);
    set(0, 1, 16'hD2, 1, 0, 0); tick();
    set(0, 1, 16'hD3, 1, 0, 0); tick();
    set(0, 0, 16'h0, 1, 0, 0); tick(2);
    set(1, 1, 16'hE1, 0, 0, 0); tick();
    set(1, 1, 16'hE2, 0, 0, 0); tick();
    set(1, 0, 16'h0, 0, 0, 1); set(0, 1, 16'hE3, 0, 0, 1); tick();
    set(1, 1, 16'hF1, 0, 0, 0); set(0, 1, 16'hF1, 0, 0, 0); tick(22);
    set(1, 0, 16'h0, 1, 0, 0); set(0, 0, 16'h0, 1, 0, 0); tick(3);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(iv[k] && !acc[k])) begin
          iv[k] = $urandom_range(0, 3) != 0;
          id[k] = 16'($urandom);
        end
        ord[k] = (c % 400 < 40) ? 1'b0 : ($urandom_range(0, 2) != 0);
        fl[k] = $urandom_range(0, 24) == 0;
        rs[k] = $urandom_range(0, 299) == 0;
      end
      tick();
    end
    for (int k = 0; k < 2; k++) set(k, 0, 16'h0, 1, 0, 0);
    tick(3);
    if (xfers == 0) begin
      fails++;
      $display("FAIL transfers: got 0 expected nonzero");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
